keypad_scan_encoder: RTL

- Upstream stage for the factory-test top's `key_in[7:0]` port.
- Scans a 4x4 active-low matrix keypad one column at a time and debounces both press and release.
- Encodes the debounced key as one byte: press flag, row index, column index.
- Emits a one-cycle strobe on each new debounced press.

---
 rtl/keypad_scan_encoder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   press and release, and encodes the accepted key as a single byte.
//
// Parameters
//   SCAN_DIV         : clock cycles per column slot (>= 4)
//   DEBOUNCE_SAMPLES : consecutive agreeing sample points to accept a
//                      press or a release (2..255)
//
// Ports
//   clk       : system clock
//   rst       : synchronous, active-high reset
//   row_n     : keypad rows, active low, asynchronous to clk
//   col_n     : column drive, active low, one-hot-low
//   key_code  : {held, 3'b000, row[1:0], col[1:0]}
//   key_valid : one-cycle pulse when a new press is accepted
//   key_held  : high while a debounced key is down (same as key_code[7])
module keypad_scan_encoder #(
   parameter int unsigned SCAN_DIV         = 1000,
   parameter int unsigned DEBOUNCE_SAMPLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [7:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [7:0]       DEB_N    = 8'(DEBOUNCE_SAMPLES);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESSED
   } state_t;

   state_t           state;
   logic [3:0]       rs_meta;
   logic [3:0]       rs_n;
   logic [DIV_W-1:0] div;
   logic [1:0]       col;
   logic [1:0]       cap_row;
   logic [7:0]       cnt;
   logic [7:0]       rcnt;

   logic             sample;
   logic [1:0]       low_row;
   logic             cap_low;
   logic [1:0]       col_next;
   logic [7:0]       cnt_inc;
   logic [7:0]       rcnt_inc;

   function automatic logic [3:0] col_drive(input logic [1:0] c);
      return ~(4'b0001 << c);
   endfunction

   assign sample   = (div == DIV_LAST);
   assign cap_low  = ~rs_n[cap_row];
   assign col_next = col + 2'd1;
   // Counters saturate at 255 instead of wrapping back to zero.
   assign cnt_inc  = (cnt  == 8'hFF) ? cnt  : cnt  + 8'd1;
   assign rcnt_inc = (rcnt == 8'hFF) ? rcnt : rcnt + 8'd1;

   // Lowest-index low row wins when several rows are low together.
   always_comb begin
      low_row = 2'd3;
      casez (rs_n)
         4'b???0: low_row = 2'd0;
         4'b??01: low_row = 2'd1;
         4'b?011: low_row = 2'd2;
         default: low_row = 2'd3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SCAN;
         rs_meta   <= '1;
         rs_n      <= '1;
         div       <= '0;
         col       <= '0;
         col_n     <= 4'b1110;
         cap_row   <= '0;
         cnt       <= '0;
         rcnt      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         rs_meta   <= row_n;
         rs_n      <= rs_meta;
         key_valid <= 1'b0;
         div       <= sample ? '0 : div + 1'b1;

         if (sample) begin
            unique case (state)
               SCAN: begin
                  if (rs_n == 4'hF) begin
                     col   <= col_next;
                     col_n <= col_drive(col_next);
                  end else begin
                     cap_row <= low_row;
                     cnt     <= 8'd1;
                     state   <= DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (cap_low) begin
                     cnt <= cnt_inc;
                     if (cnt_inc >= DEB_N) begin
                        state     <= PRESSED;
                        key_code  <= {1'b1, 3'b000, cap_row, col};
                        key_held  <= 1'b1;
                        key_valid <= 1'b1;
                        rcnt      <= '0;
                     end
                  end else begin
                     state <= SCAN;
                     col   <= col_next;
                     col_n <= col_drive(col_next);
                  end
               end
               PRESSED: begin
                  if (!cap_low) begin
                     rcnt <= rcnt_inc;
                     if (rcnt_inc >= DEB_N) begin
                        key_code[7] <= 1'b0;
                        key_held    <= 1'b0;
                        state       <= SCAN;
                        col         <= col_next;
                        col_n       <= col_drive(col_next);
                     end
                  end else begin
                     rcnt <= '0;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

endmodule
